snn_layer: RTL and testbench
============================

# snn_layer

Parametrised spiking-neuron layer: N_NEURONS leaky integrate-and-fire neurons share one binary input spike vector. On each `pulse`, every neuron serially accumulates the signed weights of its active inputs, adds its bias, updates its membrane potential and emits one spike bit. It is the generalised successor of the fixed two-neuron, five-input layer and sits between the pixel/spike encoder and the next layer, one instance per layer.

## Interface
- N_NEURONS, 2, neurons in the layer
- N_INPUTS, 5, input spike lines, also the accumulate cycle count
- W_WIDTH, 8, signed weight and bias width
- V_WIDTH, 16, signed membrane/accumulator width (≥ W_WIDTH+clog2(N_INPUTS)+1)
- THRESH, 64, firing threshold (positive, < 2^(V_WIDTH-1))
- LEAK_SHIFT, 4, leak divisor exponent (used only with SNN_LEAK_EN)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pulse  in  1  timestep strobe; sampled only in IDLE
- pixels_in  in  N_INPUTS  input spike vector, latched when pulse is accepted
- weights_in  in  N_NEURONS*N_INPUTS*W_WIDTH  weight of neuron n, input k at [(n*N_INPUTS+k)*W_WIDTH +: W_WIDTH]
- bias_in  in  N_NEURONS*W_WIDTH  bias of neuron n at [n*W_WIDTH +: W_WIDTH]
- spike_out  out  N_NEURONS  registered spike vector of the last timestep
- spike_valid  out  1  one-cycle strobe, spike_out updated
- busy  out  1  high whenever state ≠ IDLE
- overrun  out  1  sticky: a pulse arrived while busy

## Operation
- FSM: IDLE → ACCUM → FIRE → IDLE.
- IDLE: pulse=1 latches pixels_in, clears every accumulator, sets k=0, goes to ACCUM.
- ACCUM: each cycle, for each neuron, acc += sign-extended w[n][k] if latched pixel[k]=1; k increments; after k=N_INPUTS-1 goes to FIRE.
- FIRE (one cycle), per neuron: v' = sat(v_l + acc + sext(bias)), where v_l = v without SNN_LEAK_EN. If v' ≥ THRESH: spike=1, v ← v' − THRESH; else spike=0, v ← v'. spike_out registered, spike_valid=1 next cycle.
- All additions saturate at the V_WIDTH signed limits; no wrap-around.
- weights_in/bias_in must be stable while busy; they are not latched.
- A pulse while busy (ACCUM or FIRE) is dropped and sets overrun; overrun clears only on reset.
- Reset (any time, including mid-ACCUM): state IDLE, k=0, acc=0, v=0, spike_out=0, spike_valid=0, busy=0, overrun=0.

## Timing
- Pulse accepted at edge E0 → ACCUM at edges E1..E_N (N=N_INPUTS) → FIRE at edge E_{N+1}.
- spike_out/spike_valid visible after E_{N+1}: latency N_INPUTS+1 cycles from the accepting edge.
- busy high from after E0 until after E_{N+1}.
- Pulse in the spike_valid cycle is accepted (IDLE): minimum pulse period N_INPUTS+2 cycles.
- spike_out holds its value until the next FIRE.

## Configuration
- SNN_LEAK_EN defined: v_l = v − (v >>> LEAK_SHIFT), arithmetic shift, applied once per FIRE before integration.
- Undefined: v_l = v; no leak logic synthesised; LEAK_SHIFT ignored.

## Structure
- Package snn_pkg: FSM state enum (IDLE, ACCUM, FIRE), saturating signed add function, default width constants.
- Sub-module snn_neuron: one per neuron via generate. Holds acc and v, performs the accumulate and fire arithmetic. Controller FSM, k counter, pixel latch and overrun stay in snn_layer.

## Test plan
(Defaults, leak off unless stated.)
- Reset: assert reset mid-run → all outputs 0 immediately, busy=0, overrun=0.
- Single step: pixels 5'b11111, n0 weights all 20, n1 weights all 1, biases 0 → spike_valid exactly 6 cycles after the accepting edge, spike_out=2'b01, v0=36, v1=5.
- Integration: repeat the previous step → n1 spikes on the 13th pulse (v1=65→1), never before.
- Saturation: all weights −128, biases −128, pixels all ones, 300 pulses → v pinned at −32768, no spike, no wrap.
- Overrun: pulse at E0 and again at E2 → single spike_valid, overrun=1 and sticky; a pulse in the spike_valid cycle is accepted.
- Leak (SNN_LEAK_EN, LEAK_SHIFT=4): v0=36, then pixels 0 and bias 0 → v0=34, no spike. Reset mid-ACCUM, then rerun the single step → results identical to a fresh run.

Source files
------------

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared defaults, FSM encoding and saturating add for snn_layer
// Feature macro SNN_LEAK_EN (see snn_neuron) adds a per-timestep membrane leak.
package snn_pkg;

  localparam int DEF_N_NEURONS  = 2;
  localparam int DEF_N_INPUTS   = 5;
  localparam int DEF_W_WIDTH    = 8;
  localparam int DEF_V_WIDTH    = 16;
  localparam int DEF_THRESH     = 64;
  localparam int DEF_LEAK_SHIFT = 4;

  // Wide enough that no sum of two V_WIDTH-range operands can wrap before clipping.
  localparam int SAT_W = 64;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_FIRE  = 2'd2;

  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      width
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

endpackage

// File: rtl/snn_neuron.sv
// rtl/snn_neuron.sv - one LIF neuron: weight accumulator, membrane potential and spike bit
// With SNN_LEAK_EN defined the membrane decays by v >>> LEAK_SHIFT before each integration.
module snn_neuron import snn_pkg::*; #(
  parameter int W_WIDTH    = DEF_W_WIDTH,
  parameter int V_WIDTH    = DEF_V_WIDTH,
  parameter int THRESH     = DEF_THRESH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_i,
  input  logic                      accum_i,
  input  logic                      fire_i,
  input  logic                      pixel_i,
  input  logic signed [W_WIDTH-1:0] weight_i,
  input  logic signed [W_WIDTH-1:0] bias_i,
  output logic                      spike_o
);

  localparam logic signed [SAT_W-1:0] THRESH_X = SAT_W'(THRESH);

  logic signed [V_WIDTH-1:0] acc_q, acc_d;
  logic signed [V_WIDTH-1:0] v_q, v_d;
  logic                      spike_q, spike_d;
  logic signed [SAT_W-1:0]   acc_x, v_x, v_l_x, acc_sat, sum_x, fire_x;
  logic                      fires;
  logic                      unused_hi;

  always_comb begin
    acc_x = SAT_W'(acc_q);
    v_x   = SAT_W'(v_q);
`ifdef SNN_LEAK_EN
    v_l_x = v_x - (v_x >>> LEAK_SHIFT);
`else
    v_l_x = v_x;
`endif
    acc_sat = sat_add(acc_x, SAT_W'(weight_i), V_WIDTH);
    // v_l + acc cannot wrap in SAT_W bits, so one clip covers the whole three-term sum.
    sum_x   = sat_add(v_l_x + acc_x, SAT_W'(bias_i), V_WIDTH);
    fires   = (sum_x >= THRESH_X);
    fire_x  = fires ? (sum_x - THRESH_X) : sum_x;

    acc_d   = acc_q;
    v_d     = v_q;
    spike_d = spike_q;
    if (clear_i)
      acc_d = '0;
    else if (accum_i && pixel_i)
      acc_d = acc_sat[V_WIDTH-1:0];
    if (fire_i) begin
      spike_d = fires;
      v_d     = fire_x[V_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      v_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      v_q     <= v_d;
      spike_q <= spike_d;
    end
  end

  assign spike_o   = spike_q;
  assign unused_hi = ^{acc_sat[SAT_W-1:V_WIDTH], fire_x[SAT_W-1:V_WIDTH], (LEAK_SHIFT != 0)};

endmodule

// File: rtl/snn_layer.sv
// rtl/snn_layer.sv - layer of LIF neurons sharing one input spike vector, serial accumulate
// Optional macro SNN_LEAK_EN enables membrane leak inside every snn_neuron.
module snn_layer import snn_pkg::*; #(
  parameter int N_NEURONS  = DEF_N_NEURONS,
  parameter int N_INPUTS   = DEF_N_INPUTS,
  parameter int W_WIDTH    = DEF_W_WIDTH,
  parameter int V_WIDTH    = DEF_V_WIDTH,
  parameter int THRESH     = DEF_THRESH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   pulse,
  input  logic [N_INPUTS-1:0]                    pixels_in,
  input  logic [N_NEURONS*N_INPUTS*W_WIDTH-1:0]  weights_in,
  input  logic [N_NEURONS*W_WIDTH-1:0]           bias_in,
  output logic [N_NEURONS-1:0]                   spike_out,
  output logic                                   spike_valid,
  output logic                                   busy,
  output logic                                   overrun
);

  localparam int            KW     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_INPUTS - 1);

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [N_INPUTS-1:0]   pix_q, pix_d;
  logic                  overrun_q, overrun_d;
  logic                  valid_q, valid_d;
  logic                  accept;

  assign accept = (state_q == ST_IDLE) && pulse;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    pix_d     = pix_q;
    overrun_d = overrun_q | (pulse && (state_q != ST_IDLE));
    valid_d   = (state_q == ST_FIRE);
    case (state_q)
      ST_IDLE: begin
        if (pulse) begin
          state_d = ST_ACCUM;
          k_d     = '0;
          pix_d   = pixels_in;
        end
      end
      ST_ACCUM: begin
        if (k_q == K_LAST) state_d = ST_FIRE;
        else               k_d     = k_q + KW'(1);
      end
      ST_FIRE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      pix_q     <= '0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      pix_q     <= pix_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
    end
  end

  for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
    snn_neuron #(
      .W_WIDTH    (W_WIDTH),
      .V_WIDTH    (V_WIDTH),
      .THRESH     (THRESH),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_neuron (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (accept),
      .accum_i  (state_q == ST_ACCUM),
      .fire_i   (state_q == ST_FIRE),
      .pixel_i  (pix_q[k_q]),
      .weight_i (weights_in[(n*N_INPUTS + int'(k_q))*W_WIDTH +: W_WIDTH]),
      .bias_i   (bias_in[n*W_WIDTH +: W_WIDTH]),
      .spike_o  (spike_out[n])
    );
  end

  assign spike_valid = valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_snn_layer.sv
// tb/tb_snn_layer.sv - directed self-checking bench for snn_layer (default build or SNN_LEAK_EN)
module tb_snn_layer;

  localparam int NN = 2;
  localparam int NI = 5;
  localparam int WW = 8;
  localparam int VW = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                pulse;
  logic [NI-1:0]       pixels_in;
  logic [NN*NI*WW-1:0] weights_in;
  logic [NN*WW-1:0]    bias_in;
  logic [NN-1:0]       spike_out;
  logic                spike_valid;
  logic                busy;
  logic                overrun;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  snn_layer #(
    .N_NEURONS (NN), .N_INPUTS (NI), .W_WIDTH (WW), .V_WIDTH (VW),
    .THRESH (64), .LEAK_SHIFT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pulse       (pulse),
    .pixels_in   (pixels_in),
    .weights_in  (weights_in),
    .bias_in     (bias_in),
    .spike_out   (spike_out),
    .spike_valid (spike_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_params(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                            input logic [WW-1:0] b0, input logic [WW-1:0] b1);
    for (int k = 0; k < NI; k++) begin
      weights_in[k*WW +: WW]      = w0;
      weights_in[(NI+k)*WW +: WW] = w1;
    end
    bias_in = {b1, b0};
  endtask

  // Ends in the spike_valid cycle; lat = cycles from the accepting edge (capped at 20).
  task automatic run_step(output int lat);
    pulse = 1'b1;
    step();
    pulse = 1'b0;
    lat = 0;
    while (!spike_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  function automatic logic signed [31:0] v0();
    return 32'(dut.g_neuron[0].u_neuron.v_q);
  endfunction

  function automatic logic signed [31:0] v1();
    return 32'(dut.g_neuron[1].u_neuron.v_q);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nvalid;
    int badspike;
    int wrapped;

    reset = 1'b1; pulse = 1'b0; pixels_in = '0; weights_in = '0; bias_in = '0;
    step(); step();
    check("rst_spike_out", 32'(spike_out), 0);
    check("rst_valid", 32'(spike_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset = 1'b0;
    step();

    // Single step
    set_params(8'd20, 8'd1, 8'd0, 8'd0);
    pixels_in = 5'b11111;
    pulse = 1'b1;
    step();
    pulse = 1'b0;
    check("busy_after_accept", 32'(busy), 1);
    lat = 0;
    while (!spike_valid && lat < 20) begin step(); lat++; end
    check("single_latency", lat, 6);
    check("single_spike", 32'(spike_out), 1);
    check("single_busy_done", 32'(busy), 0);
    check("single_v0", v0(), 36);
    check("single_v1", v1(), 5);
    step();
    check("valid_one_cycle", 32'(spike_valid), 0);
    check("spike_hold", 32'(spike_out), 1);

`ifndef SNN_LEAK_EN
    // Integration: n1 reaches 65 on pulse 13
    for (int t = 2; t <= 12; t++) begin
      run_step(lat);
      check($sformatf("integ_spike_t%0d", t), 32'(spike_out), 1);
    end
    check("integ_v1_t12", v1(), 60);
    run_step(lat);
    check("integ_spike_t13", 32'(spike_out), 3);
    check("integ_v1_t13", v1(), 1);
    check("integ_v0_t13", v0(), 468);
`endif

    // Overrun: second pulse at E2 is dropped
    pulse = 1'b1; step();
    pulse = 1'b0; step();
    pulse = 1'b1; step();
    pulse = 1'b0;
    lat = 2;
    while (!spike_valid && lat < 20) begin step(); lat++; end
    check("ovr_latency", lat, 6);
    check("ovr_flag", 32'(overrun), 1);
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (spike_valid) nvalid++;
    end
    check("ovr_no_second_valid", nvalid, 0);
    run_step(lat);
    pulse = 1'b1;
    step();
    pulse = 1'b0;
    check("pulse_in_valid_accepted", 32'(busy), 1);
    lat = 0;
    while (!spike_valid && lat < 20) begin step(); lat++; end
    check("b2b_latency", lat, 6);
    check("ovr_sticky", 32'(overrun), 1);

    // Reset mid-ACCUM
    pulse = 1'b1; step();
    pulse = 1'b0; step(); step();
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_spike_out", 32'(spike_out), 0);
    check("midrst_valid", 32'(spike_valid), 0);
    check("midrst_overrun", 32'(overrun), 0);
    check("midrst_v0", v0(), 0);
    step();
    reset = 1'b0;
    step();
    run_step(lat);
    check("rerun_latency", lat, 6);
    check("rerun_spike", 32'(spike_out), 1);
    check("rerun_v0", v0(), 36);
    check("rerun_v1", v1(), 5);

`ifdef SNN_LEAK_EN
    set_params(8'd20, 8'd1, 8'd0, 8'd0);
    pixels_in = 5'b00000;
    run_step(lat);
    check("leak_v0", v0(), 34);
    check("leak_v1", v1(), 5);
    check("leak_spike", 32'(spike_out), 0);
`else
    // Saturation at the negative limit
    set_params(8'h80, 8'h80, 8'h80, 8'h80);
    pixels_in = 5'b11111;
    badspike = 0;
    wrapped  = 0;
    for (int t = 0; t < 300; t++) begin
      run_step(lat);
      if (spike_out != '0) badspike++;
      if (v0() > 0 || v1() > 0) wrapped++;
    end
    check("sat_no_spike", badspike, 0);
    check("sat_no_wrap", wrapped, 0);
    check("sat_v0", v0(), -32768);
    check("sat_v1", v1(), -32768);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
